// File: rtl/mips_load_store_unit_if.sv
// Data-bus interface for the MIPS load/store unit.
// Avalon-MM style single-transfer bus:
//   address     word-aligned byte address (master -> slave)
//   read/write  transfer request strobes, never both high (master -> slave)
//   byteenable  active byte lanes, little-endian (master -> slave)
//   writedata   store data (master -> slave)
//   readdata    load data, sampled when waitrequest is low (slave -> master)
//   waitrequest slave stall; master holds its request while high (slave -> master)
interface mips_load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mips_load_store_unit.sv
// MIPS memory-access stage: LW / SW / LB over a single data-bus transfer.
// Effective address = base_addr + offset (wraps mod 2^ADDR_W, no trap).
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            request, only accepted in IDLE
//   opcode           LW=100011, SW=101011, LB=100000; anything else completes
//                    with no bus access
//   base_addr/offset rs value and sign-extended I-type immediate
//   store_data       rt value written by SW
//   busy             high whenever not IDLE
//   done             one-cycle completion pulse
//   addr_error       misaligned LW/SW, only meaningful while done is high
//   load_data        LW word / sign-extended LB byte, held until next load
//   bus              data-bus master port
// Timing: start edge -> BUS -> DONE, so done arrives 2 + (stall cycles)
// after the start edge; rejected requests reach DONE one cycle after it.
module mips_load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            opcode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     offset,
  input  logic [DATA_W-1:0]     store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_error,
  output logic [DATA_W-1:0]     load_data,
  mips_load_store_unit_if.master bus
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LB = 6'b100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                lb_q, lb_d;          // transfer in flight is a byte load
  logic [1:0]          lane_q, lane_d;      // ea[1:0] of the accepted request
  logic                err_q, err_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [3:0]          be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [ADDR_W-1:0]   ea;
  logic [7:0]          lb_byte;
  logic [DATA_W-1:0]   lb_ext;

  assign ea = base_addr + offset;

  // Byte lane selected by the captured address, little-endian.
  always_comb begin
    lb_byte = bus.readdata[7:0];
    unique case (lane_q)
      2'd0: lb_byte = bus.readdata[7:0];
      2'd1: lb_byte = bus.readdata[15:8];
      2'd2: lb_byte = bus.readdata[23:16];
      2'd3: lb_byte = bus.readdata[31:24];
      default: lb_byte = bus.readdata[7:0];
    endcase
    lb_ext = {{(DATA_W-8){lb_byte[7]}}, lb_byte};
  end

  always_comb begin
    state_d     = state_q;
    lb_d        = lb_q;
    lane_d      = lane_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    be_d        = be_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lb_d   = (opcode == OP_LB);
          lane_d = ea[1:0];
          err_d  = 1'b0;
          unique case (opcode)
            OP_LW, OP_SW: begin
              if (ea[1:0] != 2'b00) begin
                // Misaligned word access: report without touching the bus.
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d   = S_BUS;
                address_d = {ea[ADDR_W-1:2], 2'b00};
                be_d      = 4'b1111;
                read_d    = (opcode == OP_LW);
                write_d   = (opcode == OP_SW);
                if (opcode == OP_SW) wdata_d = store_data;
              end
            end
            OP_LB: begin
              state_d   = S_BUS;
              address_d = {ea[ADDR_W-1:2], 2'b00};
              be_d      = 4'b0001 << ea[1:0];
              read_d    = 1'b1;
            end
            default: state_d = S_DONE;   // unsupported: done only
          endcase
        end
      end
      S_BUS: begin
        // Request registers hold their values across stalls.
        if (!bus.waitrequest) begin
          if (read_q) load_data_d = lb_q ? lb_ext : bus.readdata;
          read_d  = 1'b0;
          write_d = 1'b0;
          be_d    = 4'b0000;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lb_q        <= 1'b0;
      lane_q      <= 2'd0;
      err_q       <= 1'b0;
      load_data_q <= '0;
      address_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lb_q        <= lb_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign addr_error = (state_q == S_DONE) && err_q;
  assign load_data  = load_data_q;

  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.byteenable = be_q;
  assign bus.writedata  = wdata_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
module tb_mips_load_store_unit;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LB = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] base_addr = '0, offset = '0, store_data = '0;
  logic        busy, done, addr_error;
  logic [31:0] load_data;

  mips_load_store_unit_if bus_if ();

  mips_load_store_unit dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .base_addr(base_addr), .offset(offset), .store_data(store_data),
    .busy(busy), .done(done), .addr_error(addr_error),
    .load_data(load_data), .bus(bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ld_model = 32'h0;   // architectural load_data expectation

  // Observations of one transaction
  int          o_done_cyc, o_ndone, o_bus_cyc;
  logic        o_err, o_saw_bus, o_rd, o_wr;
  logic        o_unstable, o_both, o_err_outside, o_busy_bad;
  logic [31:0] o_addr, o_wd, o_ld;
  logic [3:0]  o_be;

  typedef struct {
    int          done_cyc;
    int          bus_cyc;
    logic        err;
    logic        bus;
    logic        rd, wr;
    logic [31:0] addr, wd, ld;
    logic [3:0]  be;
  } exp_t;

  // Reference model: straight from the ISA rules.
  function automatic exp_t predict(input logic [5:0] op, input logic [31:0] base, off, sd, rd,
                                   input int nwait, input logic [31:0] ld_in);
    exp_t e;
    logic [31:0] ea, sh;
    ea = base + off;
    e.ld = ld_in; e.addr = {ea[31:2], 2'b00}; e.wd = sd;
    e.err = 1'b0; e.bus = 1'b0; e.rd = 1'b0; e.wr = 1'b0; e.be = 4'b0; e.bus_cyc = 0;
    if (!(op == OP_LW || op == OP_SW || op == OP_LB)) begin
      e.done_cyc = 1;
    end else if (op != OP_LB && ea[1:0] != 2'b00) begin
      e.done_cyc = 1; e.err = 1'b1;
    end else begin
      e.bus = 1'b1; e.done_cyc = 2 + nwait; e.bus_cyc = nwait + 1;
      e.rd = (op != OP_SW); e.wr = (op == OP_SW);
      e.be = (op == OP_LB) ? (4'b0001 << ea[1:0]) : 4'b1111;
      if (op == OP_LW) e.ld = rd;
      if (op == OP_LB) begin
        sh = rd >> (8 * ea[1:0]);
        e.ld = {{24{sh[7]}}, sh[7:0]};
      end
    end
    return e;
  endfunction

  // Drives one request and records what the DUT did; the calling test compares.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] base, off, sd, rd,
                         input int nwait, input bit hold_start);
    int cyc, k;
    o_done_cyc = -1; o_ndone = 0; o_bus_cyc = 0; o_err = 1'b0; o_saw_bus = 1'b0;
    o_rd = 1'b0; o_wr = 1'b0; o_unstable = 1'b0; o_both = 1'b0; o_err_outside = 1'b0;
    o_busy_bad = 1'b0; o_addr = 'x; o_wd = 'x; o_ld = 'x; o_be = 'x;
    k = 0;
    @(negedge clk);
    start = 1'b1; opcode = op; base_addr = base; offset = off; store_data = sd;
    bus_if.readdata = rd; bus_if.waitrequest = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus_if.read === 1'b1 && bus_if.write === 1'b1) o_both = 1'b1;
      if (bus_if.read === 1'b1 || bus_if.write === 1'b1) begin
        k++;
        if (!o_saw_bus) begin
          o_saw_bus = 1'b1; o_addr = bus_if.address; o_be = bus_if.byteenable;
          o_wd = bus_if.writedata; o_rd = bus_if.read; o_wr = bus_if.write;
        end else if (bus_if.address !== o_addr || bus_if.byteenable !== o_be ||
                     bus_if.read !== o_rd || bus_if.write !== o_wr ||
                     (o_wr && bus_if.writedata !== o_wd)) begin
          o_unstable = 1'b1;
        end
        bus_if.waitrequest = (k <= nwait);
      end else begin
        bus_if.waitrequest = 1'b0;
      end
      if (done === 1'b1) begin
        if (o_ndone == 0) begin o_done_cyc = cyc; o_err = addr_error; o_ld = load_data; end
        o_ndone++;
      end else if (addr_error !== 1'b0) begin
        o_err_outside = 1'b1;
      end
      if (o_done_cyc < 0 || cyc == o_done_cyc) begin
        if (busy !== 1'b1) o_busy_bad = 1'b1;
      end else if (busy !== 1'b0) begin
        o_busy_bad = 1'b1;
      end
      if (o_done_cyc >= 0 && cyc >= o_done_cyc + 3) break;
      start = hold_start && (o_done_cyc < 0 || cyc == o_done_cyc);
      opcode = 6'($urandom); base_addr = $urandom; offset = $urandom; store_data = $urandom;
    end
    o_bus_cyc = k;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({busy, done, addr_error} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status busy/done/err got %b want 000", {busy, done, addr_error});
    end
    n_checks++;
    if (load_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_load_data got %h want 00000000", load_data);
    end
    n_checks++;
    if ({bus_if.read, bus_if.write, bus_if.byteenable} !== 6'b0) begin
      n_fail++; $display("FAIL reset_bus_ctl rd/wr/be got %b want 000000",
                         {bus_if.read, bus_if.write, bus_if.byteenable});
    end
    n_checks++;
    if ({bus_if.address, bus_if.writedata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_bus_data addr %h wdata %h want 0", bus_if.address, bus_if.writedata);
    end
  endtask

  task automatic test_lw();
    run_txn(OP_LW, 32'h1000, 32'h4, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    ld_model = 32'hDEADBEEF;
    n_checks++;
    if (o_addr !== 32'h1004 || o_be !== 4'b1111 || o_rd !== 1'b1 || o_wr !== 1'b0) begin
      n_fail++; $display("FAIL lw_bus addr %h be %b rd %b wr %b want 1004 1111 1 0", o_addr, o_be, o_rd, o_wr);
    end
    n_checks++;
    if (o_done_cyc !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", o_done_cyc); end
    n_checks++;
    if (o_ld !== 32'hDEADBEEF || o_err !== 1'b0) begin
      n_fail++; $display("FAIL lw_result ld %h err %b want deadbeef 0", o_ld, o_err);
    end
  endtask

  task automatic test_lb();
    run_txn(OP_LB, 32'h2000, 32'hFFFFFFFF, 32'h0, 32'h80FF7F01, 0, 1'b0);
    ld_model = 32'hFFFFFF80;
    n_checks++;
    if (o_addr !== 32'h1FFC || o_be !== 4'b1000) begin
      n_fail++; $display("FAIL lb_neg_bus addr %h be %b want 1ffc 1000", o_addr, o_be);
    end
    n_checks++;
    if (o_ld !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_neg_data got %h want ffffff80", o_ld); end
    run_txn(OP_LB, 32'h2000, 32'h1, 32'h0, 32'h80FF7F01, 0, 1'b0);
    ld_model = 32'h0000007F;
    n_checks++;
    if (o_addr !== 32'h2000 || o_be !== 4'b0010) begin
      n_fail++; $display("FAIL lb_pos_bus addr %h be %b want 2000 0010", o_addr, o_be);
    end
    n_checks++;
    if (o_ld !== 32'h0000007F) begin n_fail++; $display("FAIL lb_pos_data got %h want 0000007f", o_ld); end
  endtask

  task automatic test_sw_wait();
    run_txn(OP_SW, 32'h3000, 32'h0, 32'h12345678, 32'hA5A5A5A5, 3, 1'b0);
    n_checks++;
    if (o_wr !== 1'b1 || o_rd !== 1'b0 || o_addr !== 32'h3000 || o_wd !== 32'h12345678 || o_be !== 4'b1111) begin
      n_fail++; $display("FAIL sw_bus wr %b rd %b addr %h wd %h be %b", o_wr, o_rd, o_addr, o_wd, o_be);
    end
    n_checks++;
    if (o_bus_cyc !== 4 || o_unstable !== 1'b0) begin
      n_fail++; $display("FAIL sw_hold bus cycles %0d unstable %b want 4 0", o_bus_cyc, o_unstable);
    end
    n_checks++;
    if (o_done_cyc !== 5) begin n_fail++; $display("FAIL sw_latency got %0d want 5", o_done_cyc); end
    n_checks++;
    if (o_ld !== ld_model) begin n_fail++; $display("FAIL sw_ld_kept got %h want %h", o_ld, ld_model); end
  endtask

  task automatic test_misaligned();
    run_txn(OP_LW, 32'h1000, 32'h2, 32'h0, 32'h11111111, 0, 1'b0);
    n_checks++;
    if (o_saw_bus !== 1'b0 || o_done_cyc !== 1) begin
      n_fail++; $display("FAIL misaligned_flow bus %b done_cyc %0d want 0 1", o_saw_bus, o_done_cyc);
    end
    n_checks++;
    if (o_err !== 1'b1 || o_err_outside !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_err err %b outside %b want 1 0", o_err, o_err_outside);
    end
    n_checks++;
    if (o_ld !== ld_model) begin n_fail++; $display("FAIL misaligned_ld got %h want %h", o_ld, ld_model); end
  endtask

  task automatic test_wrap();
    run_txn(OP_LW, 32'hFFFFFFFC, 32'h8, 32'h0, 32'hCAFEF00D, 0, 1'b0);
    ld_model = 32'hCAFEF00D;
    n_checks++;
    if (o_addr !== 32'h4 || o_ld !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL wrap addr %h ld %h want 00000004 cafef00d", o_addr, o_ld);
    end
  endtask

  task automatic test_unsupported();
    run_txn(6'b000000, 32'h5000, 32'h0, 32'h0, 32'h22222222, 0, 1'b1);
    n_checks++;
    if (o_saw_bus !== 1'b0 || o_ndone !== 1 || o_done_cyc !== 1 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL unsupported bus %b ndone %0d cyc %0d err %b want 0 1 1 0",
                         o_saw_bus, o_ndone, o_done_cyc, o_err);
    end
    n_checks++;
    if (o_ld !== ld_model) begin n_fail++; $display("FAIL unsupported_ld got %h want %h", o_ld, ld_model); end
  endtask

  task automatic test_back_to_back();
    // start stays high through busy and the done cycle
    run_txn(OP_LW, 32'h6000, 32'h8, 32'h0, 32'h0BADCAFE, 2, 1'b1);
    ld_model = 32'h0BADCAFE;
    n_checks++;
    if (o_ndone !== 1 || o_done_cyc !== 4) begin
      n_fail++; $display("FAIL ignore_start ndone %0d cyc %0d want 1 4", o_ndone, o_done_cyc);
    end
    n_checks++;
    if (o_busy_bad !== 1'b0 || o_ld !== 32'h0BADCAFE || o_addr !== 32'h6008) begin
      n_fail++; $display("FAIL ignore_start_data busy_bad %b ld %h addr %h", o_busy_bad, o_ld, o_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    logic [31:0] rd;
    @(negedge clk);
    start = 1'b1; opcode = OP_LW; base_addr = 32'h4000; offset = 32'h0;
    bus_if.waitrequest = 1'b1; bus_if.readdata = 32'h33333333;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (bus_if.read !== 1'b1) begin n_fail++; $display("FAIL rstmid_enter read %b want 1", bus_if.read); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus_if.read, bus_if.write, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_abort rd/wr/busy/done got %b want 0000",
                         {bus_if.read, bus_if.write, busy, done});
    end
    ld_model = 32'h0;
    seen_done = 1'b0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1; end
    n_checks++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet activity %b want 0", seen_done); end
    bus_if.waitrequest = 1'b0;
    rd = $urandom;
    run_txn(OP_LW, 32'h4000, 32'h0, 32'h0, rd, 0, 1'b0);
    ld_model = rd;
    n_checks++;
    if (o_done_cyc !== 2 || o_ld !== rd) begin
      n_fail++; $display("FAIL rstmid_recover cyc %0d ld %h want 2 %h", o_done_cyc, o_ld, rd);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [5:0] op;
    logic [31:0] base, off, sd, rd;
    int nw;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_LB;
        default: begin
          op = 6'($urandom);
          if (op == OP_LW || op == OP_SW || op == OP_LB) op = 6'b001000;
        end
      endcase
      base = $urandom;
      off  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFFFFFC) - base[1:0] : $urandom;
      sd = $urandom; rd = $urandom; nw = $urandom_range(0, 3);
      e = predict(op, base, off, sd, rd, nw, ld_model);
      run_txn(op, base, off, sd, rd, nw, $urandom_range(0, 1) == 1);
      ld_model = e.ld;
      n_checks++;
      if (o_done_cyc !== e.done_cyc || o_ndone !== 1) begin
        n_fail++; $display("FAIL rnd%0d_timing cyc %0d ndone %0d want %0d 1", i, o_done_cyc, o_ndone, e.done_cyc);
      end
      n_checks++;
      if (o_err !== e.err || o_bus_cyc !== e.bus_cyc) begin
        n_fail++; $display("FAIL rnd%0d_flow err %b buscyc %0d want %b %0d", i, o_err, o_bus_cyc, e.err, e.bus_cyc);
      end
      n_checks++;
      if (o_ld !== e.ld) begin n_fail++; $display("FAIL rnd%0d_ld got %h want %h", i, o_ld, e.ld); end
      n_checks++;
      if ({o_both, o_unstable, o_err_outside, o_busy_bad} !== 4'b0000) begin
        n_fail++; $display("FAIL rnd%0d_protocol both/unstable/err_out/busy got %b want 0000", i,
                           {o_both, o_unstable, o_err_outside, o_busy_bad});
      end
      if (e.bus) begin
        n_checks++;
        if (o_addr !== e.addr || o_be !== e.be || o_rd !== e.rd || o_wr !== e.wr) begin
          n_fail++; $display("FAIL rnd%0d_bus addr %h be %b rd %b wr %b want %h %b %b %b",
                             i, o_addr, o_be, o_rd, o_wr, e.addr, e.be, e.rd, e.wr);
        end
        if (e.wr) begin
          n_checks++;
          if (o_wd !== e.wd) begin n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", i, o_wd, e.wd); end
        end
      end
    end
  endtask

  initial begin
    bus_if.readdata = '0;
    bus_if.waitrequest = 1'b0;
    test_reset();
    test_lw();
    test_lb();
    test_sw_wait();
    test_misaligned();
    test_wrap();
    test_unsupported();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
